oup_ulpi_regaccess: RTL
=======================

# oup_ulpi_regaccess

ULPI link-side register access engine. Accepts single read/write requests from the link controller and executes the corresponding ULPI register-write or register-read bus transaction against the PHY, using addresses from `phy_registers_t`. It sits directly upstream of the PHY register file on the ULPI bus, arbitrating with PHY-owned bus cycles through `dir`/`nxt`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles from entering CMD to completion before the transaction is abandoned with an error.

Ports:
- `clk_i` in 1: ULPI 60 MHz clock; all logic is on this one clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both are high.
- `req_write_i` in 1: 1 = register write, 0 = register read.
- `req_addr_i` in 8: register address; values ≤ 0x3F are `phy_registers_t`.
- `req_wdata_i` in 8: write data.
- `rsp_valid_o` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata_o` out 8: read data; holds the last value until the next read completes.
- `rsp_error_o` out 1: qualifies `rsp_valid_o`; timeout or illegal address.
- `ulpi_dir_i` in 1: PHY owns the bus.
- `ulpi_nxt_i` in 1: PHY throttle.
- `ulpi_data_i` in 8: bus input.
- `ulpi_data_o` out 8: bus output.
- `ulpi_data_oe_o` out 1: link drives the bus.
- `ulpi_stp_o` out 1: stop.
- `busy_o` out 1: FSM not in IDLE.

## Operation
States: IDLE, CMD, EXT (only with the extended-register feature), WR_DATA, WR_STP, RD_TURN, RD_DATA, RD_END, RESP, ABORT.

- **IDLE**
  - `req_ready_o` is 1 only when `ulpi_dir_i`=0.
  - Acceptance latches write, address and data, then goes to CMD.
  - An illegal address goes to RESP with error and no bus activity.
- **CMD**
  - Drives `{2'b10, addr[5:0]}` for a write or `{2'b11, addr[5:0]}` for a read, with `oe`=1.
  - The value is held until `nxt`=1 is sampled.
  - On `nxt`=1 the next state is WR_DATA (write) or RD_TURN (read).
- **WR_DATA**: drives wdata until `nxt`=1, then goes to WR_STP.
- **WR_STP**: `stp`=1 and data=0x00 for exactly one cycle, then RESP.
- **RD_TURN**: `oe`=0 for one turnaround cycle; `dir` is expected high.
- **RD_DATA**
  - Samples `ulpi_data_i` into `rsp_rdata_o` when `dir`=1 and `nxt`=0.
  - If `dir`=1 and `nxt`=1, the PHY has started a receive: go to ABORT.
- **RD_END**: waits for `dir`=0 (turnaround), then RESP.
- **RESP**: `rsp_valid_o`=1 for one cycle, then IDLE.
- **ABORT**
  - `oe`=0; waits for `dir`=0.
  - Then re-enters CMD with the latched request (retry). The timeout counter is not reset.
- **PHY takes the bus**: if `dir` rises in CMD, EXT or WR_DATA before `nxt`, `oe` drops the same cycle (combinational from `dir`) and the FSM goes to ABORT.
- **Timeout counter**
  - Width `$clog2(TIMEOUT_CYCLES+1)`; counts every cycle outside IDLE and RESP.
  - On reaching `TIMEOUT_CYCLES`: release the bus, go to RESP with `rsp_error_o`=1.
  - The counter saturates and clears in IDLE.

## Timing
- Reset values: `req_ready_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0x00, `rsp_error_o`=0, `ulpi_data_o`=0x00, `ulpi_data_oe_o`=0, `ulpi_stp_o`=0, `busy_o`=0; state is IDLE.
- All outputs are registered, except the `dir`-gated `oe` drop.
- Reset mid-transaction releases the bus immediately and discards the request; no response is given.
- Write with zero-stall PHY (acceptance in cycle 0):
  - CMD in cycle 1.
  - DATA in cycle 2.
  - STP in cycle 3.
  - `rsp_valid_o` in cycle 4.
- Read with zero-stall PHY:
  - CMD in cycle 1.
  - Turnaround in cycle 2.
  - Data sampled in cycle 3.
  - `dir` low in cycle 4.
  - `rsp_valid_o` in cycle 5.
- A new request is accepted no earlier than the cycle after RESP.

## Configuration
`OUP_ULPI_EXTREG_EN`:
- **Defined**
  - Addresses 0x40–0xFF are legal.
  - CMD drives `{2'bxx, 6'h2F}`, then EXT drives the full 8-bit address until `nxt`, then the FSM continues as normal.
  - Addresses ≤ 0x3F use the immediate form.
- **Undefined**
  - Address > 0x3F or == 0x2F is illegal: immediate error response.
  - The EXT state is not compiled.

## Structure
- Add `TXCMD_REGW`=2'b10, `TXCMD_REGR`=2'b11 and the FSM state enum `regaccess_state_t` to package `oup_ulpi_phyregisters`.
- One sub-module, `oup_ulpi_timeout`: a saturating counter with clear/enable inputs and an `expired` output.

## Test plan
- Write SCRATCH (0x16) with 0xA5, PHY asserts `nxt` immediately:
  - bus shows 0x96 then 0xA5, then `stp` with 0x00.
  - `rsp_valid_o` in cycle 4, `rsp_error_o`=0.
- Read VID_L (0x00) with the PHY returning 0x24:
  - CMD 0xC0, one turnaround, `rsp_rdata_o`=0x24 at cycle 5.
- `nxt` delayed 3 cycles on the CMD byte: 0x96 is held for 4 cycles and the transaction completes correctly.
- `dir` rises during WR_DATA:
  - `oe` drops the same cycle.
  - After `dir` falls, the CMD is re-issued and the write completes.
- PHY never asserts `nxt`: `rsp_error_o`=1 exactly `TIMEOUT_CYCLES` cycles after CMD entry, bus released.
- Address 0x45:
  - without `OUP_ULPI_EXTREG_EN`: immediate error, no bus activity.
  - with it: bus shows 0xAF, then 0x45, then data.

Source files
------------

// File: rtl/oup_ulpi_phyregisters.sv
// Shared definitions for the ULPI link-side register access engine:
// PHY register map, TX command prefixes, FSM state encoding and the
// address-legality helpers. OUP_ULPI_EXTREG_EN enables the extended
// (8-bit) register address space.
package oup_ulpi_phyregisters;

    // Immediate-form PHY register addresses (6-bit).
    typedef enum logic [5:0] {
        VID_L           = 6'h00,
        VID_H           = 6'h01,
        PID_L           = 6'h02,
        PID_H           = 6'h03,
        FUNC_CTRL       = 6'h04,
        IFC_CTRL        = 6'h07,
        OTG_CTRL        = 6'h0A,
        USB_INT_EN_RISE = 6'h0D,
        USB_INT_EN_FALL = 6'h10,
        USB_INT_STATUS  = 6'h13,
        USB_INT_LATCH   = 6'h14,
        DEBUG           = 6'h15,
        SCRATCH         = 6'h16,
        EXT_REG         = 6'h2F
    } phy_registers_t;

    // Upper two bits of the TX command byte.
    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    localparam logic [7:0] MAX_IMMEDIATE_ADDR = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_WR_DATA = 4'd2,
        ST_WR_STP  = 4'd3,
        ST_RD_TURN = 4'd4,
        ST_RD_DATA = 4'd5,
        ST_RD_END  = 4'd6,
        ST_RESP    = 4'd7,
`ifdef OUP_ULPI_EXTREG_EN
        ST_ABORT   = 4'd8,
        ST_EXT     = 4'd9
`else
        ST_ABORT   = 4'd8
`endif
    } regaccess_state_t;

`ifdef OUP_ULPI_EXTREG_EN
    // 0x2F is the extended-access escape code and is never a target itself.
    function automatic logic addr_is_legal(input logic [7:0] addr);
        return addr != 8'(EXT_REG);
    endfunction

    function automatic logic addr_is_extended(input logic [7:0] addr);
        return addr > MAX_IMMEDIATE_ADDR;
    endfunction
`else
    function automatic logic addr_is_legal(input logic [7:0] addr);
        return (addr <= MAX_IMMEDIATE_ADDR) && (addr[5:0] != EXT_REG);
    endfunction
`endif

endpackage

// File: rtl/oup_ulpi_timeout.sv
// Saturating transaction timeout counter. 'expired' asserts in the cycle
// whose clock edge brings the count to LIMIT, so the owner can act on that
// same edge and complete exactly LIMIT enabled cycles after it started.
module oup_ulpi_timeout #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] FULL = W'(LIMIT);

    logic [W-1:0] count;

    // Count enabled cycles, holding at LIMIT until cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != FULL)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/oup_ulpi_regaccess.sv
// ULPI link-side register access engine: executes single register writes
// and reads against the PHY, yielding to PHY-owned bus cycles via dir/nxt
// and retrying the command after the PHY releases the bus.
// Optional macro OUP_ULPI_EXTREG_EN adds extended (8-bit) addressing.
module oup_ulpi_regaccess
    import oup_ulpi_phyregisters::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_error_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe_o,
    output logic       ulpi_stp_o,
    output logic       busy_o
);

    regaccess_state_t state, state_next, after_addr;

    logic       write_q;
    logic [7:0] addr_q, wdata_q, rd_buf;
    logic       cur_write;
    logic [7:0] cur_addr, cur_wdata, cmd_addr;
    logic       accept, expired, count_clear, count_enable;
    logic       err_next, sample_rd, rd_done;
    logic [7:0] data_next;
    logic       oe_next, stp_next;

    logic       ready_q, rsp_valid_q, rsp_error_q, oe_q, stp_q, busy_q;
    logic [7:0] rsp_rdata_q, data_q;

    // The PHY grabbing the bus must silence the link within the same cycle.
    assign req_ready_o    = ready_q & ~ulpi_dir_i;
    assign ulpi_data_oe_o = oe_q & ~ulpi_dir_i;
    assign accept         = req_valid_i & req_ready_o;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;
    assign ulpi_data_o = data_q;
    assign ulpi_stp_o  = stp_q;
    assign busy_o      = busy_q;

    // The timeout spans every retry of one request; it only clears in IDLE.
    assign count_clear  = (state == ST_IDLE);
    assign count_enable = (state != ST_IDLE) && (state != ST_RESP);

    oup_ulpi_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (count_clear),
        .enable  (count_enable),
        .expired (expired)
    );

    // Next-state logic: timeout overrides everything, dir preempts the link.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_next = state;
        err_next   = 1'b0;
        sample_rd  = 1'b0;
        rd_done    = 1'b0;
        after_addr = write_q ? ST_WR_DATA : ST_RD_TURN;
        if (expired) begin
            state_next = ST_RESP;
            err_next   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (addr_is_legal(req_addr_i)) begin
                            state_next = ST_CMD;
                        end else begin
                            state_next = ST_RESP;
                            err_next   = 1'b1;
                        end
                    end
                end
                ST_CMD: begin
                    if (ulpi_dir_i) begin
                        state_next = ST_ABORT;
                    end else if (ulpi_nxt_i) begin
`ifdef OUP_ULPI_EXTREG_EN
                        state_next = addr_is_extended(addr_q) ? ST_EXT : after_addr;
`else
                        state_next = after_addr;
`endif
                    end
                end
`ifdef OUP_ULPI_EXTREG_EN
                ST_EXT: begin
                    if (ulpi_dir_i) begin
                        state_next = ST_ABORT;
                    end else if (ulpi_nxt_i) begin
                        state_next = after_addr;
                    end
                end
`endif
                ST_WR_DATA: begin
                    if (ulpi_dir_i) begin
                        state_next = ST_ABORT;
                    end else if (ulpi_nxt_i) begin
                        state_next = ST_WR_STP;
                    end
                end
                ST_WR_STP:  state_next = ST_RESP;
                ST_RD_TURN: state_next = ST_RD_DATA;
                ST_RD_DATA: begin
                    if (ulpi_dir_i) begin
                        if (ulpi_nxt_i) begin
                            state_next = ST_ABORT;
                        end else begin
                            sample_rd  = 1'b1;
                            state_next = ST_RD_END;
                        end
                    end
                end
                ST_RD_END: begin
                    if (!ulpi_dir_i) begin
                        rd_done    = 1'b1;
                        state_next = ST_RESP;
                    end
                end
                ST_RESP: state_next = ST_IDLE;
                ST_ABORT: begin
                    if (!ulpi_dir_i) begin
                        state_next = ST_CMD;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Bus output values for the state being entered, registered on the edge.
    always_comb begin
        cur_write = accept ? req_write_i : write_q;
        cur_addr  = accept ? req_addr_i  : addr_q;
        cur_wdata = accept ? req_wdata_i : wdata_q;
`ifdef OUP_ULPI_EXTREG_EN
        cmd_addr  = addr_is_extended(cur_addr) ? 8'(EXT_REG) : cur_addr;
`else
        cmd_addr  = cur_addr;
`endif
        data_next = 8'h00;
        oe_next   = 1'b0;
        stp_next  = 1'b0;
        case (state_next)
            ST_CMD: begin
                oe_next   = 1'b1;
                data_next = {(cur_write ? TXCMD_REGW : TXCMD_REGR), 6'h00} | (cmd_addr & 8'h3F);
            end
`ifdef OUP_ULPI_EXTREG_EN
            ST_EXT: begin
                oe_next   = 1'b1;
                data_next = cur_addr;
            end
`endif
            ST_WR_DATA: begin
                oe_next   = 1'b1;
                data_next = cur_wdata;
            end
            ST_WR_STP: begin
                oe_next  = 1'b1;
                stp_next = 1'b1;
            end
            default: ;
        endcase
    end

    // State, request latch, read capture and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rd_buf      <= 8'h00;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            data_q      <= 8'h00;
            oe_q        <= 1'b0;
            stp_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (sample_rd) begin
                rd_buf <= ulpi_data_i;
            end
            // Read data is only published once the read completes cleanly.
            if (rd_done) begin
                rsp_rdata_q <= rd_buf;
            end
            ready_q     <= (state_next == ST_IDLE);
            rsp_valid_q <= (state_next == ST_RESP);
            rsp_error_q <= err_next;
            data_q      <= data_next;
            oe_q        <= oe_next;
            stp_q       <= stp_next;
            busy_q      <= (state_next != ST_IDLE);
        end
    end

endmodule
